// File: rtl/bp_be_pipe_imul_pkg.sv
// Shared types for the iterative integer multiply pipe.
package bp_be_pipe_imul_pkg;

  typedef enum logic [1:0] {
    e_mul    = 2'b00,
    e_mulh   = 2'b01,
    e_mulhsu = 2'b10,
    e_mulhu  = 2'b11
  } bp_be_mul_op_e;

  typedef enum logic [1:0] {
    e_imul_idle,
    e_imul_calc,
    e_imul_neg,
    e_imul_done
  } bp_be_imul_state_e;

  // rs1 is treated as signed for every op except MULHU
  function automatic logic rs1_signed(input bp_be_mul_op_e op);
    return op != e_mulhu;
  endfunction

  // rs2 is treated as signed only for MUL and MULH
  function automatic logic rs2_signed(input bp_be_mul_op_e op);
    return (op == e_mul) || (op == e_mulh);
  endfunction

endpackage

// File: rtl/bp_be_pipe_imul_if.sv
// Issue / writeback bundle between the scheduler and the multiply pipe.
interface bp_be_pipe_imul_if
  import bp_be_pipe_imul_pkg::*;
#(
  parameter int unsigned width_p = 64
) ();

  logic               v_i;
  logic               ready_o;
  bp_be_mul_op_e      op_i;
  logic               opw_i;
  logic [width_p-1:0] rs1_i;
  logic [width_p-1:0] rs2_i;
  logic               flush_i;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport master (
    output v_i, op_i, opw_i, rs1_i, rs2_i, flush_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, op_i, opw_i, rs1_i, rs2_i, flush_i, yumi_i,
    output ready_o, v_o, data_o
  );

endinterface

// File: rtl/bp_be_imul_step.sv
// One radix-2^bits_per_iter_p partial-product step: magnitude x digit plus
// the current upper accumulator slice.
module bp_be_imul_step #(
  parameter int unsigned width_p         = 64,
  parameter int unsigned bits_per_iter_p = 8
) (
  input  logic [width_p-1:0]                 mag,
  input  logic [bits_per_iter_p-1:0]         digit,
  input  logic [width_p-1:0]                 acc_hi,
  output logic [width_p+bits_per_iter_p-1:0] sum
);

  localparam int unsigned sum_w_lp = width_p + bits_per_iter_p;

  // acc_hi < 2^w and mag*digit <= (2^w-1)(2^b-1), so the sum fits in w+b bits
  always_comb begin
    sum = sum_w_lp'(acc_hi) + (sum_w_lp'(mag) * sum_w_lp'(digit));
  end

endmodule

// File: rtl/bp_be_pipe_imul.sv
// Iterative RV64M multiplier with ready/valid issue, yumi writeback,
// zero-operand early-out and flush.
module bp_be_pipe_imul
  import bp_be_pipe_imul_pkg::*;
#(
  parameter int unsigned width_p         = 64,
  parameter int unsigned bits_per_iter_p = 8
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  bp_be_pipe_imul_if.slave    mul_if
);

  localparam int unsigned iters_lp = width_p / bits_per_iter_p;
  localparam int unsigned half_lp  = width_p / 2;
  localparam int unsigned cnt_w_lp = $clog2(iters_lp + 1);
  localparam int unsigned sum_w_lp = width_p + bits_per_iter_p;

  bp_be_imul_state_e state_r, state_n;

  logic [cnt_w_lp-1:0]  cnt_r;
  logic [width_p-1:0]   a_mag_r;
  logic [width_p-1:0]   b_r;
  logic                 neg_r;
  bp_be_mul_op_e        op_r;
  logic                 opw_r;
  logic [2*width_p-1:0] acc_r;
  logic [width_p-1:0]   data_r;

  logic [width_p-1:0]   opa, opb, mag_a, mag_b;
  logic                 sign_a, sign_b, zero_op, accept, last_iter;
  logic [sum_w_lp-1:0]  step_sum;
  logic [2*width_p-1:0] prod;
  logic [width_p-1:0]   result;

  assign mul_if.ready_o = (state_r == e_imul_idle);
  assign mul_if.v_o     = (state_r == e_imul_done);
  assign mul_if.data_o  = data_r;

  assign accept = mul_if.v_i & mul_if.ready_o & ~mul_if.flush_i;

  // Operand extension, sign detection and magnitude
  always_comb begin
    opa = mul_if.rs1_i;
    opb = mul_if.rs2_i;
    if (mul_if.opw_i) begin
      opa = {{half_lp{mul_if.rs1_i[half_lp-1]}}, mul_if.rs1_i[half_lp-1:0]};
      opb = {{half_lp{mul_if.rs2_i[half_lp-1]}}, mul_if.rs2_i[half_lp-1:0]};
    end
    sign_a  = rs1_signed(mul_if.op_i) & opa[width_p-1];
    sign_b  = rs2_signed(mul_if.op_i) & opb[width_p-1];
    mag_a   = sign_a ? -opa : opa;
    mag_b   = sign_b ? -opb : opb;
    zero_op = (opa == '0) || (opb == '0);
  end

  assign last_iter = (cnt_r == cnt_w_lp'(opw_r ? (iters_lp / 2 - 1) : (iters_lp - 1)));

  bp_be_imul_step #(
    .width_p        (width_p),
    .bits_per_iter_p(bits_per_iter_p)
  ) step (
    .mag   (a_mag_r),
    .digit (b_r[bits_per_iter_p-1:0]),
    .acc_hi(acc_r[2*width_p-1:width_p]),
    .sum   (step_sum)
  );

  // The accumulator shifts right each step, so a word op that stops after
  // half the steps leaves its product offset by half_lp bits.
  always_comb begin
    prod = opw_r ? (acc_r >> half_lp) : acc_r;
    if (neg_r) begin
      prod = -prod;
    end
    if (op_r == e_mul) begin
      result = opw_r ? {{half_lp{prod[half_lp-1]}}, prod[half_lp-1:0]}
                     : prod[width_p-1:0];
    end else begin
      result = prod[2*width_p-1:width_p];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_imul_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_imul_idle: if (accept) state_n = zero_op ? e_imul_done : e_imul_calc;
      e_imul_calc: begin
        if (mul_if.flush_i)  state_n = e_imul_idle;
        else if (last_iter)  state_n = e_imul_neg;
      end
      e_imul_neg:  state_n = mul_if.flush_i ? e_imul_idle : e_imul_done;
      e_imul_done: if (mul_if.flush_i || mul_if.yumi_i) state_n = e_imul_idle;
      default:     state_n = e_imul_idle;
    endcase
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r   <= '0;
      a_mag_r <= '0;
      b_r     <= '0;
      neg_r   <= 1'b0;
      op_r    <= e_mul;
      opw_r   <= 1'b0;
      acc_r   <= '0;
      data_r  <= '0;
    end else if (accept) begin
      cnt_r   <= '0;
      a_mag_r <= mag_a;
      b_r     <= mag_b;
      neg_r   <= sign_a ^ sign_b;
      op_r    <= mul_if.op_i;
      opw_r   <= mul_if.opw_i;
      acc_r   <= '0;
      if (zero_op) begin
        data_r <= '0;
      end
    end else if (state_r == e_imul_calc) begin
      cnt_r <= cnt_r + cnt_w_lp'(1);
      b_r   <= b_r >> bits_per_iter_p;
      acc_r <= {step_sum, acc_r[width_p-1:bits_per_iter_p]};
    end else if (state_r == e_imul_neg) begin
      data_r <= result;
    end
  end

endmodule

// File: tb/tb_bp_be_pipe_imul.sv
// Scoreboard bench for bp_be_pipe_imul: a driver issues ops and queues the
// expected result and arrival cycle; a monitor drains and compares.
module tb_bp_be_pipe_imul;
  import bp_be_pipe_imul_pkg::*;

  localparam int unsigned W = 64;

  typedef struct {
    logic [63:0] data;
    int unsigned cyc;
    bit          hold5;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        busy = 1'b0;
  logic        chk_en = 1'b0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_be_pipe_imul_if #(.width_p(W)) bus ();

  bp_be_pipe_imul #(
    .width_p        (W),
    .bits_per_iter_p(8)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .mul_if   (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: full-width product of the architecturally extended operands
  function automatic logic [63:0] model(input bp_be_mul_op_e op, input logic opw,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    if (opw) begin
      xa = {{96{a[31]}}, a[31:0]};
      xb = {{96{b[31]}}, b[31:0]};
      p  = xa * xb;
      return {{32{p[31]}}, p[31:0]};
    end
    xa = (op == e_mulhu) ? {64'b0, a} : {{64{a[63]}}, a};
    xb = (op == e_mul || op == e_mulh) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = xa * xb;
    return (op == e_mul) ? p[63:0] : p[127:64];
  endfunction

  function automatic int unsigned latency(input logic opw, input logic [63:0] a, input logic [63:0] b);
    if (opw ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0)) return 1;
    return opw ? 6 : 10;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'(unsigned'($urandom_range(0, 255)));
      5: v = {32'h0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Wait for ready (junk v_i while busy), issue one op, optionally scoreboard it.
  // Returns just after the accept edge.
  task automatic issue(input bp_be_mul_op_e op, input logic opw, input logic [63:0] a,
                       input logic [63:0] b, input bit push, input bit hold5);
    int unsigned t = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.ready_o && t < 60) begin
      bus.v_i   = 1'($urandom_range(0, 1));
      bus.op_i  = bp_be_mul_op_e'($urandom_range(0, 3));
      bus.opw_i = 1'b0;
      bus.rs1_i = {$urandom, $urandom};
      bus.rs2_i = {$urandom, $urandom};
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      bus.v_i = 1'b0;
      timeout("issue_ready");
      return;
    end
    bus.v_i   = 1'b1;
    bus.op_i  = op;
    bus.opw_i = opw;
    bus.rs1_i = a;
    bus.rs2_i = b;
    if (push) begin
      e.data  = model(op, opw, a, b);
      e.cyc   = cyc + latency(opw, a, b);
      e.hold5 = hold5;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.v_i = 1'b0;
    busy    = 1'b1;
  endtask

  task automatic flush_after(input int unsigned n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    busy        = 1'b0;
  endtask

  // ready_o must track the bench's own notion of an op in flight
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) check("ready_o", 64'(bus.ready_o), 64'(!busy));
    end
  end

  // Monitor: compare each result, hold it a while, then consume it
  initial begin
    exp_t        e;
    logic [63:0] held;
    int unsigned hold;
    forever begin
      @(negedge clk);
      if (rst_n && bus.v_o) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_v_o: got data %h with no op outstanding", bus.data_o);
          hold = 0;
        end else begin
          e = sb.pop_front();
          check("data_o", bus.data_o, e.data);
          check("latency", 64'(cyc), 64'(e.cyc));
          hold = e.hold5 ? 5 : $urandom_range(0, 2);
        end
        held = bus.data_o;
        repeat (hold) begin
          @(negedge clk);
          check("hold_v_o", 64'(bus.v_o), 64'd1);
          check("hold_data_o", bus.data_o, held);
        end
        bus.yumi_i = 1'b1;
        @(posedge clk);
        #1;
        bus.yumi_i = 1'b0;
        busy       = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!bus.yumi_i || bus.v_o) else $error("yumi_i without v_o");
      assert (!(bus.v_i && bus.opw_i) || bus.op_i == e_mul) else $error("opw_i with non-MUL op");
    end
  end

  initial begin
    bp_be_mul_op_e op;
    logic          opw;
    logic [63:0]   a, b;
    int unsigned   t;

    bus.v_i = 1'b0; bus.op_i = e_mul; bus.opw_i = 1'b0;
    bus.rs1_i = '0; bus.rs2_i = '0; bus.flush_i = 1'b0; bus.yumi_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ready_o", 64'(bus.ready_o), 64'd1);
    check("reset_v_o", 64'(bus.v_o), 64'd0);
    check("reset_data_o", bus.data_o, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed cases
    issue(e_mul,    1'b0, 64'd3, 64'd5, 1'b1, 1'b1);
    issue(e_mulh,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    issue(e_mulh,   1'b0, '1, '1, 1'b1, 1'b0);
    issue(e_mulhu,  1'b0, '1, '1, 1'b1, 1'b0);
    issue(e_mulhsu, 1'b0, '1, '1, 1'b1, 1'b0);
    issue(e_mul,    1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 1'b1, 1'b0);
    issue(e_mulhu,  1'b0, 64'd0, 64'hDEAD, 1'b1, 1'b0);
    issue(e_mul,    1'b0, -64'sd7, 64'd9, 1'b1, 1'b0);

    // Flush in the 4th CALC cycle, then a clean op at full latency
    issue(e_mul, 1'b0, 64'd11, 64'd13, 1'b0, 1'b0);
    flush_after(3);
    issue(e_mul, 1'b0, 64'd7, 64'd6, 1'b1, 1'b0);

    // Reset mid-CALC: outputs clear immediately, ready_o high
    issue(e_mul, 1'b0, 64'd5, 64'd5, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_v_o", 64'(bus.v_o), 64'd0);
    check("rst_data_o", bus.data_o, 64'd0);
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
    busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // flush_i with v_i in IDLE must block the accept
    @(negedge clk);
    bus.v_i = 1'b1; bus.op_i = e_mul; bus.rs1_i = 64'd2; bus.rs2_i = 64'd3;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.v_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_flush_v_o", 64'(bus.v_o), 64'd0);
    end

    // Randomised traffic with occasional flushes in CALC/NEG
    for (int i = 0; i < 200; i++) begin
      op  = bp_be_mul_op_e'($urandom_range(0, 3));
      opw = (op == e_mul) && ($urandom_range(0, 3) == 0);
      a   = pick();
      b   = pick();
      if (latency(opw, a, b) > 1 && $urandom_range(0, 7) == 0) begin
        issue(op, opw, a, b, 1'b0, 1'b0);
        flush_after($urandom_range(0, latency(opw, a, b) - 2));
      end else begin
        issue(op, opw, a, b, 1'b1, 1'b0);
      end
    end

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) timeout("drain_scoreboard");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_imul.md
Name: bp_be_pipe_imul

Overview:
- Parametrised iterative integer multiplier for the BE calculator. Covers all RV64M multiply ops: MUL, MULH, MULHSU, MULHU and MULW.
- Replaces the fixed-latency, low-half-only multiply pipe with a ready/valid unit. The unit has data-dependent latency, a zero-operand early-out and flush support.
- Sits beside the long-latency divide pipe. The scheduler issues to it through v_i/ready_o, and writeback drains it through v_o/yumi_i.

Parameters:
- width_p, 64, register width. Must be even.
- bits_per_iter_p, 8, multiplier bits retired per CALC cycle. Must divide width_p/2.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  request valid
- ready_o  out  1  unit can accept a request
- op_i  in  2  bp_be_mul_op_e
- opw_i  in  1  word op. Legal only with op_i=MUL, giving MULW.
- rs1_i  in  width_p  operand A
- rs2_i  in  width_p  operand B
- flush_i  in  1  kill any in-flight op
- v_o  out  1  result valid
- data_o  out  width_p  result
- yumi_i  in  1  consumer takes the result. Legal only when v_o=1.

Behaviour:
- States: IDLE, CALC, NEG, DONE.
- Asynchronous reset: state=IDLE, counter=0, v_o=0, data_o=0. ready_o=1 whenever state=IDLE, including during reset.
- ready_o is asserted only in IDLE. v_o is asserted only in DONE.
- Accept occurs on v_i & ready_o & ~flush_i. On accept, load:
  - operand signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - opw: operands are the low width_p/2 bits sign-extended to width_p.
  - |A| and |B| as width_p-bit unsigned magnitudes. The most-negative value maps to 2^(width_p-1).
  - neg flag = signA XOR signB.
  - op, and a 2*width_p-bit accumulator cleared to 0.
- Zero early-out: if either operand is zero at accept (after opw extension), go IDLE->DONE with data_o=0. Latency is 1 cycle: v_o is high in the first cycle after the accept edge.
- Otherwise go IDLE->CALC. Each CALC cycle:
  - add |A| × (next bits_per_iter_p bits of |B|) to the accumulator at the current shift;
  - increment the counter.
- CALC lasts N cycles, where N = width_p/bits_per_iter_p, or N/2 when opw. The last iteration goes to NEG.
- NEG (1 cycle): two's-complement the 2*width_p-bit product if neg. Then select into data_o:
  - MUL: low width_p bits.
  - MULH/MULHSU/MULHU: high width_p bits.
  - MULW: low width_p/2 bits sign-extended.
  - Go to DONE.
- Total latency: N+2 cycles from accept to first v_o cycle. Defaults: 10 cycles for 64-bit ops, 6 for MULW.
- DONE: v_o=1 and data_o is held stable until yumi_i. yumi_i -> IDLE, so ready_o is high the following cycle. There is no same-cycle re-accept in DONE.
- flush_i in CALC, NEG or DONE: go to IDLE next cycle, v_o=0, result discarded.
- flush_i in IDLE: blocks the accept even if v_i=1.
- flush_i together with yumi_i in DONE: result counts as consumed; next state is IDLE.
- data_o after flush or yumi is don't-care and must not be relied upon. data_o is registered.
- v_i while not ready_o is ignored, with no side effects.
- Illegal inputs (opw with op≠MUL, yumi_i without v_o): behaviour unspecified. Covered by assertions in the bench.

Decomposition:
- bp_be_pkg gains:
  - bp_be_mul_op_e: e_mul=2'b00, e_mulh=2'b01, e_mulhsu=2'b10, e_mulhu=2'b11;
  - bp_be_imul_state_e.
- Natural sub-module: bp_be_imul_step. It is a combinational bits_per_iter_p-bit partial-product adder: magnitude × digit + accumulator slice.
- The FSM, counter and negate/select logic live in the top module.

Test Plan:
- MUL rs1=3, rs2=5, width_p=64 -> v_o exactly 10 cycles after accept, data_o=15. ready_o low throughout until the cycle after yumi_i.
- MULH rs1=rs2=0x8000_0000_0000_0000 -> data_o=0x4000_0000_0000_0000. MULH rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> data_o=0.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> data_o=0xFFFF_FFFF_FFFF_FFFE. MULHSU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0xFFFF_FFFF_FFFF_FFFF -> data_o=0xFFFF_FFFF_FFFF_FFFF.
- MULW rs1=0x1234_5678_7FFF_FFFF, rs2=2 -> latency 6, data_o=0xFFFF_FFFF_FFFF_FFFE. MULHU rs1=0, rs2=0xDEAD -> latency 1, data_o=0.
- Issue MUL, assert flush_i in the 4th CALC cycle -> v_o never rises, ready_o=1 next cycle. A following MUL 7×6 returns 42 at full latency. flush_i with v_i in IDLE -> no accept.
- Hold yumi_i low 5 cycles in DONE -> v_o and data_o stable. Assert reset_n_i low mid-CALC -> v_o=0 and data_o=0 immediately, ready_o=1.
